interrupt_ctrl: RTL
===================

# interrupt_ctrl

Interrupt controller and arbiter for the 8085 core. It latches and masks the five interrupt sources (TRAP, RST7.5, RST6.5, RST5.5, INTR) and holds the INTE flag and the SIM/RIM state. At each instruction boundary flagged by the decoding/sequencing logic, it selects one winning source and presents it, with its restart vector, to the machine-cycle sequencer until that sequencer acknowledges it.

## Interface
- No parameters.
- phi1  in  1  single clock; all state updates on posedge phi1
- reset  in  1  synchronous, active-high
- trap, rst75, rst65, rst55, intr  in  1 each  interrupt pins, already synchronised to phi1
- sid  in  1  serial input data pin
- int_sample  in  1  one-cycle pulse at the last T-state of each instruction (instruction boundary)
- int_ack  in  1  one-cycle pulse: sequencer has started servicing the presented interrupt
- ei_exec, di_exec  in  1  one-cycle pulse when EI / DI executes
- sim_wr  in  1  one-cycle pulse when SIM executes
- sim_data  in  8  accumulator value for SIM
- int_take  out  1  a winning interrupt is presented
- int_src  out  5  one-hot winner: [4] TRAP, [3] RST7.5, [2] RST6.5, [1] RST5.5, [0] INTR
- int_vector  out  16  restart address: 0x0024, 0x003C, 0x0034, 0x002C; 0x0000 for INTR (sequencer runs an INTA fetch)
- inte  out  1  interrupt-enable flag
- sod  out  1  serial output data latch
- rim_data  out  8  {sid, I7.5, I6.5, I5.5, inte, M7.5, M6.5, M5.5}; combinational

## Operation
- **Edge detectors.** trap_prev and r75_prev are registered copies of the pins. On reset they load the current pin value, so a pin that is high during reset does not produce an edge.
- **trap_latch.** Set on a trap rising edge. Cleared by int_ack with int_src[4], or by reset. The TRAP request is trap_latch & trap (edge plus level).
- **r75_latch.** Set on an rst75 rising edge regardless of mask. Cleared by int_ack with int_src[3], by sim_wr with sim_data[4]=1, or by reset. If a set and a clear occur in the same cycle, set wins.
- **RST6.5 / RST5.5.** Level-sensitive; nothing is latched. I6.5 = rst65 and I5.5 = rst55 in rim_data, unmasked.
- **INTR.** Level-sensitive and lowest priority.
- **Masks M7.5, M6.5, M5.5.**
  - Reset value is 1 (all masked).
  - On sim_wr with sim_data[3]=1 (MSE), the masks load sim_data[2:0].
  - On sim_wr with sim_data[6]=1 (SDE), sod <= sim_data[7].
- **Eligibility.**
  - TRAP: eligible whenever requested.
  - RST7.5: r75_latch & ~M7.5 & inte.
  - RST6.5: rst65 & ~M6.5 & inte.
  - RST5.5: rst55 & ~M5.5 & inte.
  - INTR: intr & inte.
  - Fixed priority: TRAP > 7.5 > 6.5 > 5.5 > INTR.
- **INTE and EI delay.**
  - di_exec clears inte.
  - ei_exec sets ei_arm. At the next int_sample, arbitration uses the old inte, then inte <= 1 and ei_arm <= 0. The first interrupt is therefore taken at the second boundary after EI.
  - If di_exec and ei_exec occur in the same cycle, DI wins and ei_arm is cleared.
- **State machine.**
  - IDLE: on int_sample with at least one eligible source, register int_src (one-hot winner) and int_vector, then go to TAKE.
  - TAKE: int_take=1 and the registered outputs are frozen. Further int_sample pulses are ignored, and newly arriving higher-priority sources do not pre-empt.
  - TAKE with int_ack: clear inte and ei_arm, clear the winner's latch (TRAP / 7.5 only), go to IDLE.
  - int_ack while in IDLE: ignored.
- **Reset**, including mid-operation: state IDLE, int_take=0, int_src=0, int_vector=0, inte=0, ei_arm=0, both latches 0, masks 111, sod=0.

## Timing
- Latency: int_sample in cycle N gives int_take=1 in cycle N+1.
- int_ack in cycle M gives int_take=0 and inte=0 in cycle M+1. A new int_sample in cycle M+1 sees the cleared state, so only TRAP can win.
- Edges: a pin rising in cycle N sets its latch at the end of N. An int_sample in N+1 sees it.
- SIM effects (masks, R7.5, sod) are visible in rim_data in the cycle after sim_wr.
- int_sample arriving in the same cycle as sim_wr arbitrates with the pre-SIM state.

## Test plan
- **Reset defaults:** apply reset with trap=1 held. Require all outputs at their reset values and rim_data=0x07 (sid=0). Release reset, pulse int_sample: no take, because there was no edge.
- **EI delay:** ei_exec, rst55=1, sim_wr 0x08 (unmask all). First int_sample gives no take. Second int_sample gives int_take=1, int_src=00010, int_vector=0x002C. int_ack clears inte; rim_data[3]=0.
- **Priority:** inte=1, masks 000, rst75 edge with rst65=intr=1. Sample: int_src=01000, vector 0x003C. Ack clears r75_latch; next EI+2 samples give 6.5 / 0x0034.
- **TRAP:** inte=0, masks 111, trap rises and stays high. Sample gives int_src=10000, vector 0x0024. Separately, trap rises then falls before sample: no take.
- **R7.5 clear race:** masks 111, rst75 edge in the same cycle as sim_wr 0x10. Require rim_data[6]=1. A later sim_wr 0x10 gives rim_data[6]=0.
- **Mid-operation reset:** reset asserted during TAKE. Require int_take=0 next cycle, latches cleared, masks 111; a later int_ack is ignored.

Source files
------------

// File: rtl/interrupt_ctrl.sv
// 8085 interrupt controller: latches/masks TRAP, RST7.5/6.5/5.5 and INTR, keeps INTE and SIM/RIM state,
// and presents one fixed-priority winner per instruction boundary until the sequencer acknowledges it.
//
// state | meaning
// IDLE  | waiting for an instruction boundary with an eligible source
// TAKE  | winner presented on int_src/int_vector, waiting for int_ack
module interrupt_ctrl (
  input  logic        phi1,
  input  logic        reset,
  input  logic        trap,
  input  logic        rst75,
  input  logic        rst65,
  input  logic        rst55,
  input  logic        intr,
  input  logic        sid,
  input  logic        int_sample,
  input  logic        int_ack,
  input  logic        ei_exec,
  input  logic        di_exec,
  input  logic        sim_wr,
  input  logic [7:0]  sim_data,
  output logic        int_take,
  output logic [4:0]  int_src,
  output logic [15:0] int_vector,
  output logic        inte,
  output logic        sod,
  output logic [7:0]  rim_data
);

  typedef enum logic {S_IDLE, S_TAKE} state_t;

  state_t      state_q, state_d;
  logic        trap_prev_q, r75_prev_q;
  logic        trap_latch_q, trap_latch_d;
  logic        r75_latch_q, r75_latch_d;
  logic [2:0]  mask_q, mask_d;
  logic        sod_q, sod_d;
  logic        inte_q, inte_d;
  logic        ei_arm_q, ei_arm_d;
  logic [4:0]  src_q, src_d;
  logic [15:0] vec_q, vec_d;

  logic [4:0]  elig;
  logic [4:0]  win;
  logic [15:0] win_vec;
  logic        ack_take, grant;
  logic        unused_sim_bit;

  assign unused_sim_bit = sim_data[5];

  // mask_q = {M7.5, M6.5, M5.5}; TRAP needs edge latched and level still high
  assign elig = {trap_latch_q & trap,
                 r75_latch_q & ~mask_q[2] & inte_q,
                 rst65 & ~mask_q[1] & inte_q,
                 rst55 & ~mask_q[0] & inte_q,
                 intr & inte_q};

  always_comb begin
    win     = 5'b00000;
    win_vec = 16'h0000;
    if (elig[4]) begin
      win = 5'b10000; win_vec = 16'h0024;
    end else if (elig[3]) begin
      win = 5'b01000; win_vec = 16'h003C;
    end else if (elig[2]) begin
      win = 5'b00100; win_vec = 16'h0034;
    end else if (elig[1]) begin
      win = 5'b00010; win_vec = 16'h002C;
    end else if (elig[0]) begin
      win = 5'b00001; win_vec = 16'h0000;
    end
  end

  assign ack_take = int_ack && (state_q == S_TAKE);
  assign grant    = int_sample && (state_q == S_IDLE) && (|elig);

  always_comb begin
    trap_latch_d = trap_latch_q;
    r75_latch_d  = r75_latch_q;
    mask_d       = mask_q;
    sod_d        = sod_q;
    inte_d       = inte_q;
    ei_arm_d     = ei_arm_q;
    src_d        = src_q;
    vec_d        = vec_q;

    if (ack_take && src_q[4]) trap_latch_d = 1'b0;
    if (trap && !trap_prev_q) trap_latch_d = 1'b1;

    if ((ack_take && src_q[3]) || (sim_wr && sim_data[4])) r75_latch_d = 1'b0;
    if (rst75 && !r75_prev_q) r75_latch_d = 1'b1;

    if (sim_wr && sim_data[3]) mask_d = sim_data[2:0];
    if (sim_wr && sim_data[6]) sod_d = sim_data[7];

    // EI takes effect only after the boundary that follows it has arbitrated
    if (int_sample && ei_arm_q) begin
      inte_d   = 1'b1;
      ei_arm_d = 1'b0;
    end
    if (ei_exec) ei_arm_d = 1'b1;
    if (ack_take || di_exec) begin
      inte_d   = 1'b0;
      ei_arm_d = 1'b0;
    end

    if (grant) begin
      src_d = win;
      vec_d = win_vec;
    end else if (ack_take) begin
      src_d = 5'b00000;
      vec_d = 16'h0000;
    end
  end

  always_ff @(posedge phi1) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant)    state_d = S_TAKE;
      S_TAKE:  if (ack_take) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    int_take = (state_q == S_TAKE);
  end

  always_ff @(posedge phi1) begin
    if (reset) begin
      trap_prev_q  <= trap;
      r75_prev_q   <= rst75;
      trap_latch_q <= 1'b0;
      r75_latch_q  <= 1'b0;
      mask_q       <= 3'b111;
      sod_q        <= 1'b0;
      inte_q       <= 1'b0;
      ei_arm_q     <= 1'b0;
      src_q        <= 5'b00000;
      vec_q        <= 16'h0000;
    end else begin
      trap_prev_q  <= trap;
      r75_prev_q   <= rst75;
      trap_latch_q <= trap_latch_d;
      r75_latch_q  <= r75_latch_d;
      mask_q       <= mask_d;
      sod_q        <= sod_d;
      inte_q       <= inte_d;
      ei_arm_q     <= ei_arm_d;
      src_q        <= src_d;
      vec_q        <= vec_d;
    end
  end

  assign int_src    = src_q;
  assign int_vector = vec_q;
  assign inte       = inte_q;
  assign sod        = sod_q;
  assign rim_data   = {sid, r75_latch_q, rst65, rst55, inte_q, mask_q};

endmodule
